// File: rtl/rs_latch_driver_pkg.sv
// Shared definitions for the gated RS latch driver.
// Holds the FSM state encoding and the default timing constants used by
// rs_latch_driver and rs_latch_driver_debounce_cell.
package rs_latch_driver_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDriveS = 2'd1,
        StDriveR = 2'd2
    } state_t;

    localparam int unsigned DB_CYCLES_DEF = 4;
    localparam int unsigned PULSE_LEN_DEF = 2;

endpackage

// File: rtl/rs_latch_driver_debounce_cell.sv
// Debounce cell: 2-FF synchronizer, saturating stability counter and the
// debounced level, plus a one-cycle pulse when the level rises.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   btn   - raw asynchronous button input
//   level - debounced button level
//   rise  - high for one cycle after the debounced level goes 0->1
module rs_latch_driver_debounce_cell
    import rs_latch_driver_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    // The counter reaching DB_CYCLES means this edge is the last one needed.
    localparam logic [7:0] CntLast = 8'(DB_CYCLES - 32'd1);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CntLast) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            cnt_d   = '0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/rs_latch_driver.sv
// Gated RS latch driver: turns two bouncy buttons into clean, mutually
// exclusive, fixed-length S/R pulses with the gate E asserted alongside.
// Optional macro RS_SET_PRIORITY_EN: when defined, a pending set is serviced
// before a pending reset; otherwise reset wins.
// Ports:
//   CLK   - system clock
//   RST   - synchronous active-high reset
//   BTN_S - raw set button
//   BTN_R - raw reset button
//   S, R  - registered drives to the latch, never both high
//   E     - registered latch gate, high exactly when S or R is high
//   BUSY  - high while a drive pulse is in progress
module rs_latch_driver
    import rs_latch_driver_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_S,
    input  logic BTN_R,
    output logic S,
    output logic R,
    output logic E,
    output logic BUSY
);

    localparam logic [3:0] PulseLast = 4'(PULSE_LEN - 32'd1);

    logic       level_s, level_r, rise_s, rise_r;
    logic       want_s, want_r;
    state_t     state_q, state_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic       pend_s_q, pend_s_d, pend_r_q, pend_r_d;
    logic       s_q, r_q, e_q, busy_q;

    rs_latch_driver_debounce_cell #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db_s (
        .clk  (CLK),
        .rst  (RST),
        .btn  (BTN_S),
        .level(level_s),
        .rise (rise_s)
    );

    rs_latch_driver_debounce_cell #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db_r (
        .clk  (CLK),
        .rst  (RST),
        .btn  (BTN_R),
        .level(level_r),
        .rise (rise_r)
    );

    // A rise arriving this cycle counts as pending so it is not lost.
    assign want_s = pend_s_q | rise_s;
    assign want_r = pend_r_q | rise_r;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        pend_s_d = want_s;
        pend_r_d = want_r;
        case (state_q)
            StIdle: begin
                pcnt_d = '0;
`ifdef RS_SET_PRIORITY_EN
                if (want_s) begin
                    state_d  = StDriveS;
                    pend_s_d = 1'b0;
                end else if (want_r) begin
                    state_d  = StDriveR;
                    pend_r_d = 1'b0;
                end
`else
                if (want_r) begin
                    state_d  = StDriveR;
                    pend_r_d = 1'b0;
                end else if (want_s) begin
                    state_d  = StDriveS;
                    pend_s_d = 1'b0;
                end
`endif
            end
            StDriveS, StDriveR: begin
                // Always fall back to idle, which guarantees a gap between pulses.
                if (pcnt_q == PulseLast) begin
                    state_d = StIdle;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                pcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            pcnt_q   <= '0;
            pend_s_q <= 1'b0;
            pend_r_q <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            e_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            pend_s_q <= pend_s_d;
            pend_r_q <= pend_r_d;
            s_q      <= (state_d == StDriveS);
            r_q      <= (state_d == StDriveR);
            e_q      <= (state_d == StDriveS) || (state_d == StDriveR);
            busy_q   <= (state_d != StIdle);
        end
    end

    assign S    = s_q;
    assign R    = r_q;
    assign E    = e_q;
    assign BUSY = busy_q;

endmodule
